// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register unit's single write port between the core writeback
// path (priority, no backpressure) and a buffered long-latency return path
// (valid/ready into a small FIFO). A clear sequencer zeroes x1..x31.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   wb_en/wb_rd/wb_data   core writeback request, zero added latency
//   lr_valid/lr_ready     return-path handshake, lr_rd/lr_data payload
//   clr_req/clr_busy      start clear (pulse) / clear in progress
//   wb_drop               sticky: core writeback dropped during a clear
//   lr_count              FIFO occupancy (0..FIFO_DEPTH)
//   RUWr/rd/datawr        register unit write port
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_en,
    input  logic [ADDR_W-1:0]             wb_rd,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic                          lr_valid,
    output logic                          lr_ready,
    input  logic [ADDR_W-1:0]             lr_rd,
    input  logic [DATA_W-1:0]             lr_data,
    input  logic                          clr_req,
    output logic                          clr_busy,
    output logic                          wb_drop,
    output logic [$clog2(FIFO_DEPTH):0]   lr_count,
    output logic                          RUWr,
    output logic [ADDR_W-1:0]             rd,
    output logic [DATA_W-1:0]             datawr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Highest register index; the clear walks 1..LAST_IDX.
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   clr_idx_r, clr_idx_nx_s;
    logic                wb_drop_r, wb_drop_nx_s;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [ADDR_W-1:0]   fifo_rd_r   [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];

    logic                wb_hit_s;
    logic                flush_s;
    logic                pop_s;
    logic                push_s;
    logic                lr_ready_s;
    logic                ruwr_s;
    logic [ADDR_W-1:0]   rd_s;
    logic [DATA_W-1:0]   datawr_s;

    // A writeback to x0 is treated as no request at all.
    assign wb_hit_s   = wb_en && (wb_rd != {ADDR_W{1'b0}});
    // Ready depends only on registered state, never on lr_valid or wb_en.
    assign lr_ready_s = (state_r == ST_IDLE) && (count_r < DEPTH_C);
    assign push_s     = lr_valid && lr_ready_s;

    // Next-state logic for the IDLE/CLEAR sequencer and the sticky drop flag.
    always_comb begin
        state_nx_s   = state_r;
        clr_idx_nx_s = clr_idx_r;
        wb_drop_nx_s = wb_drop_r;
        flush_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nx_s   = ST_CLEAR;
                    clr_idx_nx_s = FIRST_IDX;
                    wb_drop_nx_s = 1'b0;
                    flush_s      = 1'b1;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (wb_hit_s) begin
                    wb_drop_nx_s = 1'b1;
                end else begin
                    wb_drop_nx_s = wb_drop_r;
                end
                if (clr_idx_r == LAST_IDX) begin
                    state_nx_s   = ST_IDLE;
                    clr_idx_nx_s = FIRST_IDX;
                end else begin
                    clr_idx_nx_s = clr_idx_r + FIRST_IDX;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                clr_idx_nx_s = FIRST_IDX;
                flush_s      = 1'b1;
            end
        endcase
    end

    // Write-port arbitration: core writeback, else FIFO head, else idle; clear overrides.
    always_comb begin
        ruwr_s   = 1'b0;
        rd_s     = {ADDR_W{1'b0}};
        datawr_s = {DATA_W{1'b0}};
        pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb_hit_s) begin
                    ruwr_s   = 1'b1;
                    rd_s     = wb_rd;
                    datawr_s = wb_data;
                end else if (count_r != {CNT_W{1'b0}}) begin
                    // Entries addressed to x0 are popped but never written.
                    pop_s    = 1'b1;
                    ruwr_s   = (fifo_rd_r[rd_ptr_r] != {ADDR_W{1'b0}});
                    rd_s     = fifo_rd_r[rd_ptr_r];
                    datawr_s = fifo_data_r[rd_ptr_r];
                end else begin
                    ruwr_s   = 1'b0;
                end
            end
            ST_CLEAR: begin
                ruwr_s   = 1'b1;
                rd_s     = clr_idx_r;
                datawr_s = {DATA_W{1'b0}};
            end
            default: begin
                ruwr_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state, clear index and sticky drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            clr_idx_r <= FIRST_IDX;
            wb_drop_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            clr_idx_r <= clr_idx_nx_s;
            wb_drop_r <= wb_drop_nx_s;
        end
    end

    // FIFO pointers and occupancy; a flush on entering CLEAR wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_r[i]   <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s && !flush_s) begin
            fifo_rd_r[wr_ptr_r]   <= lr_rd;
            fifo_data_r[wr_ptr_r] <= lr_data;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_r[i]   <= fifo_rd_r[i];
                fifo_data_r[i] <= fifo_data_r[i];
            end
        end
    end

    // The write port is combinational, so it is forced quiet while reset is held.
    assign RUWr     = reset && ruwr_s;
    assign rd       = reset ? rd_s : {ADDR_W{1'b0}};
    assign datawr   = reset ? datawr_s : {DATA_W{1'b0}};
    assign lr_ready = reset && lr_ready_s;
    assign clr_busy = reset && (state_r == ST_CLEAR);
    assign wb_drop  = wb_drop_r;
    assign lr_count = count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          lr_valid = 1'b0;
    logic          lr_ready;
    logic [AW-1:0] lr_rd = '0;
    logic [DW-1:0] lr_data = '0;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          wb_drop;
    logic [$clog2(DEPTH):0] lr_count;
    logic          RUWr;
    logic [AW-1:0] rd;
    logic [DW-1:0] datawr;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .wb_drop(wb_drop), .lr_count(lr_count),
        .RUWr(RUWr), .rd(rd), .datawr(datawr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue for the FIFO, a flag and index for the clear.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_clear = 1'b0;
    int   m_idx = 1;
    bit   m_drop = 1'b0;

    always @(negedge clk) begin
        bit   hit;
        bit   e_ruwr, e_ready, e_busy;
        int   e_rd;
        logic [DW-1:0] e_data;
        ent_t e;
        if (!reset) begin
            chk("rst_RUWr", RUWr, 0);
            chk("rst_lr_ready", lr_ready, 0);
            chk("rst_clr_busy", clr_busy, 0);
            chk("rst_rd", rd, 0);
            chk("rst_datawr", datawr, 0);
            chk("rst_lr_count", lr_count, 0);
            chk("rst_wb_drop", wb_drop, 0);
            q.delete();
            m_clear = 1'b0;
            m_idx = 1;
            m_drop = 1'b0;
        end else begin
            hit = wb_en && (wb_rd != 0);
            e_ruwr = 1'b0; e_rd = 0; e_data = '0;
            if (m_clear) begin
                e_ruwr = 1'b1; e_rd = m_idx; e_busy = 1'b1; e_ready = 1'b0;
            end else begin
                e_busy = 1'b0;
                e_ready = (q.size() < DEPTH);
                if (hit) begin
                    e_ruwr = 1'b1; e_rd = wb_rd; e_data = wb_data;
                end else if (q.size() > 0) begin
                    e_ruwr = (q[0].rd != 0); e_rd = q[0].rd; e_data = q[0].data;
                end
            end
            chk("RUWr", RUWr, e_ruwr);
            chk("rd", rd, e_rd);
            chk("datawr", datawr, e_data);
            chk("lr_ready", lr_ready, e_ready);
            chk("clr_busy", clr_busy, e_busy);
            chk("lr_count", lr_count, q.size());
            chk("wb_drop", wb_drop, m_drop);
            // advance model to the next cycle (inputs are stable until posedge+1)
            if (m_clear) begin
                if (hit) m_drop = 1'b1;
                m_idx++;
                if (m_idx == 32) begin
                    m_clear = 1'b0;
                    m_idx = 1;
                end
            end else begin
                if (!hit && q.size() > 0) void'(q.pop_front());
                if (lr_valid && e_ready) begin
                    e.rd = lr_rd; e.data = lr_data;
                    q.push_back(e);
                end
                if (clr_req) begin
                    q.delete();
                    m_clear = 1'b1;
                    m_idx = 1;
                    m_drop = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        lr_valid = 1'b0; lr_rd = '0; lr_data = '0;
        clr_req = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) step();
        chk("pin_rst_lr_ready", lr_ready, 0);
        reset = 1'b1;

        // Core writeback goes straight through in the same cycle.
        step();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        chk("pin_wb_RUWr", RUWr, 1);
        chk("pin_wb_rd", rd, 5);
        chk("pin_wb_data", datawr, 32'hDEADBEEF);
        chk("pin_wb_count", lr_count, 0);

        // Buffer two returns behind a busy core writeback, then drain in order.
        step();
        wb_rd = 5'd3; wb_data = 32'h3333;
        lr_valid = 1'b1; lr_rd = 5'd7; lr_data = 32'h11;
        step();
        lr_rd = 5'd8; lr_data = 32'h22;
        step();
        lr_valid = 1'b0;
        #1;
        chk("pin_full_count", lr_count, 2);
        chk("pin_full_ready", lr_ready, 0);
        step();
        step();
        wb_en = 1'b0;
        #1;
        chk("pin_drain1_rd", rd, 7);
        chk("pin_drain1_data", datawr, 32'h11);
        chk("pin_drain1_count", lr_count, 2);
        step();
        #1;
        chk("pin_drain2_rd", rd, 8);
        chk("pin_drain2_count", lr_count, 1);
        step();
        #1;
        chk("pin_drain_empty", lr_count, 0);

        // A return addressed to x0 is discarded without a write.
        lr_valid = 1'b1; lr_rd = 5'd0; lr_data = 32'hAA;
        step();
        lr_valid = 1'b0;
        #1;
        chk("pin_x0_RUWr", RUWr, 0);
        chk("pin_x0_count", lr_count, 1);
        step();

        // Clear with one entry pending; core write during clear is dropped.
        wb_en = 1'b1; wb_rd = 5'd3;
        lr_valid = 1'b1; lr_rd = 5'd12; lr_data = 32'h55;
        step();
        lr_valid = 1'b0; clr_req = 1'b1;
        #1;
        chk("pin_preclr_count", lr_count, 1);
        step();
        clr_req = 1'b0; wb_rd = 5'd9; wb_data = 32'h99;
        #1;
        chk("pin_clr_busy", clr_busy, 1);
        chk("pin_clr_rd", rd, 1);
        chk("pin_clr_count", lr_count, 0);
        chk("pin_clr_data", datawr, 0);
        for (int i = 2; i <= 31; i++) begin
            step();
            wb_en = 1'b0;
            clr_req = (i == 10);
        end
        step();
        clr_req = 1'b0;
        #1;
        chk("pin_post_busy", clr_busy, 0);
        chk("pin_post_drop", wb_drop, 1);
        chk("pin_post_ready", lr_ready, 1);

        // Next clear acceptance clears wb_drop; reset mid-clear stops at once.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #1;
        chk("pin_drop_cleared", wb_drop, 0);
        chk("pin_clr2_rd", rd, 1);
        repeat (9) step();
        #1;
        chk("pin_clr2_rd10", rd, 10);
        reset = 1'b0;
        #1;
        chk("pin_rstclr_RUWr", RUWr, 0);
        chk("pin_rstclr_busy", clr_busy, 0);
        repeat (2) step();
        reset = 1'b1;
        #1;
        chk("pin_rel_ready", lr_ready, 1);
        chk("pin_rel_busy", clr_busy, 0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #1;
        chk("pin_clr3_rd", rd, 1);
        repeat (31) step();

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            step();
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
            wb_data  = $urandom;
            lr_valid = ($urandom_range(0, 2) != 0);
            lr_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
            lr_data  = $urandom;
            clr_req  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
        step();
        idle_inputs();
        reset = 1'b1;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register unit's single write port between two requesters. The core writeback path has priority and no backpressure. A long-latency return path (load/MMIO returns) uses a valid/ready handshake and is buffered in a small FIFO. The block also has a clear sequencer that zeroes x1..x31 on request. It sits between the writeback stage and the register unit's RUWr/rd/datawr inputs.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width (fixed for 32 registers)
FIFO_DEPTH, 2, return-path buffer entries; power of 2, must be 2 or 4

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wb_en  in  1  core writeback request this cycle
wb_rd  in  ADDR_W  core writeback destination
wb_data  in  DATA_W  core writeback data
lr_valid  in  1  return-path request valid
lr_ready  out  1  return-path can accept
lr_rd  in  ADDR_W  return-path destination
lr_data  in  DATA_W  return-path data
clr_req  in  1  start clear sequence (pulse)
clr_busy  out  1  clear sequence in progress
wb_drop  out  1  sticky: a core writeback was dropped during a clear
lr_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
RUWr  out  1  register unit write enable
rd  out  ADDR_W  register unit write index
datawr  out  DATA_W  register unit write data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; FIFO pointers and lr_count=0; clear counter=1; wb_drop=0.
  - While reset is low: RUWr=0, lr_ready=0, clr_busy=0, rd=0, datawr=0.
- States:
  - IDLE: normal arbitration.
  - CLEAR: sequential zeroing.
- Write port drive is combinational from current state, inputs and FIFO head. Core writeback has zero added latency.
- IDLE arbitration, in priority order:
  - If wb_en=1 and wb_rd!=0: RUWr=1, rd=wb_rd, datawr=wb_data. The FIFO does not pop.
  - Otherwise, if lr_count>0: pop the FIFO head. RUWr=(head.rd!=0), rd=head.rd, datawr=head.data. An entry with rd=0 is discarded without a write.
  - Otherwise: RUWr=0, rd=0, datawr=0.
  - A wb_en with wb_rd=0 counts as no request; the FIFO may drain in that cycle.
- FIFO push:
  - lr_ready = (state==IDLE) && (lr_count<FIFO_DEPTH). It depends on registered state only, with no combinational path from lr_valid or wb_en.
  - A push happens when lr_valid && lr_ready.
  - When full, a pop in the same cycle does not enable a push.
  - Push and pop in the same cycle are legal when not full; lr_count is unchanged.
  - Entries drain in FIFO order, one per cycle at most.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE to CLEAR on clr_req=1 at a clock edge:
  - That cycle's arbitration still completes normally.
  - The FIFO is flushed at the transition (lr_count=0); in-flight returns are discarded.
  - The clear counter loads 1. wb_drop is cleared on this transition.
- CLEAR:
  - Each cycle: RUWr=1, rd=counter, datawr=0, clr_busy=1, lr_ready=0.
  - The counter increments every cycle. When counter=31, the next state is IDLE and the counter reloads to 1.
  - The sequence takes exactly 31 cycles (x1..x31); x0 is never written.
- clr_req is ignored while in CLEAR; the sequence does not restart.
- wb_en=1 with wb_rd!=0 during CLEAR: the write is dropped and wb_drop sets to 1 and stays set until reset or the next clr_req acceptance. wb_en with wb_rd=0 during CLEAR does not set wb_drop.
- Reset asserted mid-CLEAR or mid-drain: the block returns to IDLE immediately, with the FIFO empty and no further writes.
- lr_count always equals the number of valid entries, in the range 0..FIFO_DEPTH.

Test Plan:
- Reset release, then wb_en=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle RUWr=1, rd=5, datawr=0xDEADBEEF; lr_count=0.
- FIFO buffering and drain order:
  - Hold wb_en=1 with wb_rd=3 for 4 cycles while pushing lr (rd=7, 0x11) then lr (rd=8, 0x22) -> lr_ready drops after 2 pushes and lr_count=2.
  - Then release wb_en -> writes rd=7 0x11, then rd=8 0x22 on consecutive cycles; lr_count goes 2,1,0.
- Push lr (rd=0, 0xAA) with wb idle -> entry popped, RUWr=0, lr_count returns to 0.
- Clear sequence:
  - With 1 FIFO entry pending, pulse clr_req -> lr_count=0 next cycle.
  - 31 consecutive writes follow: rd=1..31, datawr=0, clr_busy=1, lr_ready=0.
  - IDLE again on cycle 32.
- During CLEAR: wb_en=1, wb_rd=9 -> no write to 9 and wb_drop=1 sticky after the clear. A later clr_req clears wb_drop.
- Assert reset low at cycle 10 of CLEAR -> RUWr=0 and clr_busy=0 immediately. After release: IDLE, lr_ready=1, clear counter restarts at 1 on the next clr_req.
